// File: rtl/m_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock with one ripple slice.
// Latency: w_out_valid rises exactly WIDTH/DIGIT edges after the accepting edge; initiation interval >= K+2.
// Backpressure: result held in DONE until w_out_ready; w_in_ready only in IDLE, with no DONE->accept bypass.
//
// Ports: w_clk / w_rst_n (async, active-low) | w_in_valid, w_in_ready, w_a, w_b, w_cin : operand handshake
//        w_out_valid, w_out_ready, w_s, w_c : registered result handshake
// Optional macro SERIAL_ADDER_SUB_EN adds w_sub (subtract A-B, w_c=1 means no borrow)
//        and w_ovf (registered signed overflow of the performed operation).
module m_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_in_valid,
    output logic             w_in_ready,
    input  logic [WIDTH-1:0] w_a,
    input  logic [WIDTH-1:0] w_b,
    input  logic             w_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             w_sub,
    output logic             w_ovf,
`endif
    output logic             w_out_valid,
    input  logic             w_out_ready,
    output logic [WIDTH-1:0] w_s,
    output logic             w_c
);

    // Refuse to build with a digit size that does not tile the operand.
    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("m_serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             last_digit;
    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] b_cap;
    logic             cin_cap;

`ifdef SERIAL_ADDER_SUB_EN
    // Operand sign bits as actually added (B already inverted for subtract);
    // overflow is then decided from the final sum's sign alone.
    logic a_msb_q, a_msb_d;
    logic bx_msb_q, bx_msb_d;
    logic ovf_q, ovf_d;
`endif

    assign accept     = (state_q == IDLE) && w_in_valid;
    assign last_digit = (state_q == BUSY) && (cnt_q == CW'(K - 1));

    // One DIGIT-wide ripple slice over the low digit of each shift register.
    assign slice    = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
    // New digit enters at the top so the sum is aligned after K shifts.
    assign sum_next = (sum_sh_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));

    // ---------------- state register ----------------
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_in_valid)  state_d = BUSY;
            BUSY:    if (last_digit)  state_d = DONE;
            DONE:    if (w_out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        w_in_ready  = (state_q == IDLE);
        w_out_valid = out_valid_q;
        w_s         = s_q;
        w_c         = c_q;
`ifdef SERIAL_ADDER_SUB_EN
        w_ovf       = ovf_q;
`endif
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        b_cap       = w_b;
        cin_cap     = w_cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (w_sub) begin
            b_cap   = ~w_b;
            cin_cap = 1'b1;
        end
        a_msb_d     = a_msb_q;
        bx_msb_d    = bx_msb_q;
        ovf_d       = ovf_q;
`endif
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        carry_d     = carry_q;
        s_d         = s_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            a_sh_d   = w_a;
            b_sh_d   = b_cap;
            carry_d  = cin_cap;
            cnt_d    = '0;
`ifdef SERIAL_ADDER_SUB_EN
            a_msb_d  = w_a[WIDTH-1];
            bx_msb_d = b_cap[WIDTH-1];
`endif
        end else if (state_q == BUSY) begin
            a_sh_d   = a_sh_q >> DIGIT;
            b_sh_d   = b_sh_q >> DIGIT;
            sum_sh_d = sum_next;
            carry_d  = slice[DIGIT];
            cnt_d    = cnt_q + CW'(1);
            if (last_digit) begin
                s_d         = sum_next;
                c_d         = slice[DIGIT];
                out_valid_d = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
                ovf_d       = (a_msb_q == bx_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
`endif
            end
        end else if (state_q == DONE && w_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            a_msb_q     <= 1'b0;
            bx_msb_q    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_SUB_EN
            a_msb_q     <= a_msb_d;
            bx_msb_q    <= bx_msb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_m_serial_adder.sv
// Bench for m_serial_adder: three instances (8/1, 16/4, 8/8) sharing clock and reset,
// directed vector table, hand-written backpressure and mid-operation reset sequences,
// then random operations checked against an arithmetic reference model.
module tb_m_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2:0]       in_valid, in_ready, cin_i, sub_i, out_valid, out_ready, c_o, ovf_o;
    logic [2:0][15:0] a_i, b_i;
    logic [7:0]       s0, s2;
    logic [15:0]      s1;

    int n_tests = 0;
    int n_fail  = 0;

    m_serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_in_valid(in_valid[0]), .w_in_ready(in_ready[0]),
        .w_a(a_i[0][7:0]), .w_b(b_i[0][7:0]), .w_cin(cin_i[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .w_sub(sub_i[0]), .w_ovf(ovf_o[0]),
`endif
        .w_out_valid(out_valid[0]), .w_out_ready(out_ready[0]),
        .w_s(s0), .w_c(c_o[0])
    );

    m_serial_adder #(.WIDTH(16), .DIGIT(4)) u1 (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_in_valid(in_valid[1]), .w_in_ready(in_ready[1]),
        .w_a(a_i[1]), .w_b(b_i[1]), .w_cin(cin_i[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .w_sub(sub_i[1]), .w_ovf(ovf_o[1]),
`endif
        .w_out_valid(out_valid[1]), .w_out_ready(out_ready[1]),
        .w_s(s1), .w_c(c_o[1])
    );

    m_serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_in_valid(in_valid[2]), .w_in_ready(in_ready[2]),
        .w_a(a_i[2][7:0]), .w_b(b_i[2][7:0]), .w_cin(cin_i[2]),
`ifdef SERIAL_ADDER_SUB_EN
        .w_sub(sub_i[2]), .w_ovf(ovf_o[2]),
`endif
        .w_out_valid(out_valid[2]), .w_out_ready(out_ready[2]),
        .w_s(s2), .w_c(c_o[2])
    );

`ifndef SERIAL_ADDER_SUB_EN
    assign ovf_o = '0;
`endif

    typedef struct {
        int          u;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        eovf;
    } vec_t;

    vec_t vt[$];

    function automatic int width_of(input int u);
        return (u == 1) ? 16 : 8;
    endfunction

    function automatic int k_of(input int u);
        case (u)
            0:       return 8;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] get_s(input int u);
        case (u)
            0:       return {8'h00, s0};
            1:       return s1;
            default: return {8'h00, s2};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    task automatic model(input int u, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         output logic [15:0] s, output logic c, output logic ovf);
        longint w, m, ua, ub, sa, sb, r;
        w  = width_of(u);
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        if (sub) begin
            r = ua - ub;
            c = (ua >= ub);
        end else begin
            r = ua + ub + longint'(cin);
            c = (r >= m);
        end
        r  = r & (m - 1);
        s  = r[15:0];
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r  = sub ? (sa - sb) : (sa + sb + longint'(cin));
        ovf = (r < -(m / 2)) || (r > (m / 2) - 1);
    endtask

    task automatic start_op(input int u, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub, input string name);
        int e;
        e = 0;
        while (in_ready[u] !== 1'b1 && e < 50) begin
            tick();
            e++;
        end
        chk({name, "_ready"}, in_ready[u], 1);
        in_valid[u] = 1'b1;
        a_i[u] = a;
        b_i[u] = b;
        cin_i[u] = cin;
        sub_i[u] = sub;
        tick();
        // Scramble operands during BUSY: they must not reach the result.
        in_valid[u] = 1'b0;
        a_i[u] = 16'($urandom);
        b_i[u] = 16'($urandom);
        cin_i[u] = 1'($urandom);
        sub_i[u] = 1'($urandom);
        chk({name, "_busy_rdy"}, in_ready[u], 0);
    endtask

    task automatic finish_op(input int u, input logic [15:0] es, input logic ec,
                             input logic eovf, input string name);
        int e;
        e = 0;
        while (out_valid[u] !== 1'b1 && e < k_of(u) + 3) begin
            chk({name, "_busy_rdy"}, in_ready[u], 0);
            tick();
            e++;
        end
        chk({name, "_latency"}, e, k_of(u));
        chk({name, "_s"}, get_s(u), es);
        chk({name, "_c"}, c_o[u], ec);
`ifdef SERIAL_ADDER_SUB_EN
        chk({name, "_ovf"}, ovf_o[u], eovf);
`else
        if (eovf === 1'bx) chk({name, "_eovf"}, 1, 0);
`endif
    endtask

    task automatic release_op(input int u, input string name);
        logic [15:0] s_ref;
        logic        c_ref;
        s_ref = get_s(u);
        c_ref = c_o[u];
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk({name, "_hold_v"}, out_valid[u], 1);
            chk({name, "_hold_s"}, get_s(u), s_ref);
            chk({name, "_hold_c"}, c_o[u], c_ref);
        end
        out_ready[u] = 1'b1;
        tick();
        out_ready[u] = 1'b0;
        chk({name, "_ack_v"}, out_valid[u], 0);
        chk({name, "_ack_rdy"}, in_ready[u], 1);
    endtask

    task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic ec, input logic eovf, input string name);
        start_op(u, a, b, cin, sub, name);
        finish_op(u, es, ec, eovf, name);
        release_op(u, name);
    endtask

    initial begin
        logic [15:0] ra, rb, ms, s_hold;
        logic        rcin, rsub, mc, movf, c_hold;
        int          u;

        in_valid  = '0;
        out_ready = '0;
        cin_i     = '0;
        sub_i     = '0;
        a_i       = '0;
        b_i       = '0;
        rst_n     = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_rdy%0d", i), in_ready[i], 1);
            chk($sformatf("reset_vld%0d", i), out_valid[i], 0);
            chk($sformatf("reset_s%0d", i), get_s(i), 0);
            chk($sformatf("reset_c%0d", i), c_o[i], 0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Directed vectors: {unit, a, b, cin, sub, sum, carry, overflow}
        vt.push_back('{0, 16'h005A, 16'h0033, 1'b0, 1'b0, 16'h008D, 1'b0, 1'b1});
        vt.push_back('{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vt.push_back('{0, 16'h00FF, 16'h00FF, 1'b1, 1'b0, 16'h00FF, 1'b1, 1'b0});
        vt.push_back('{1, 16'h1234, 16'hF00F, 1'b0, 1'b0, 16'h0243, 1'b1, 1'b0});
        vt.push_back('{1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0});
        vt.push_back('{2, 16'h005A, 16'h0033, 1'b0, 1'b0, 16'h008D, 1'b0, 1'b1});
        vt.push_back('{2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vt.push_back('{0, 16'h0010, 16'h0020, 1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0});
        vt.push_back('{0, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1});
        vt.push_back('{1, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0});
        vt.push_back('{2, 16'h007F, 16'h00FF, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b1});
`endif
        foreach (vt[i]) begin
            run_op(vt[i].u, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub,
                   vt[i].es, vt[i].ec, vt[i].eovf, $sformatf("vec%0d", i));
        end

        // Backpressure: DONE held 5 cycles with a live, changing request.
        start_op(0, 16'h0011, 16'h0022, 1'b0, 1'b0, "bp");
        finish_op(0, 16'h0033, 1'b0, 1'b0, "bp");
        s_hold = get_s(0);
        c_hold = c_o[0];
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_i[0] = 16'($urandom);
            b_i[0] = 16'($urandom);
            tick();
            chk("bp_stall_v", out_valid[0], 1);
            chk("bp_stall_s", get_s(0), s_hold);
            chk("bp_stall_c", c_o[0], c_hold);
            chk("bp_stall_rdy", in_ready[0], 0);
        end
        a_i[0] = 16'h0040;
        b_i[0] = 16'h0005;
        cin_i[0] = 1'b1;
        sub_i[0] = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        chk("bp_exit_v", out_valid[0], 0);
        chk("bp_exit_rdy", in_ready[0], 1);
        tick();
        in_valid[0] = 1'b0;
        chk("bp_next_busy", in_ready[0], 0);
        finish_op(0, 16'h0046, 1'b0, 1'b0, "bp_next");
        release_op(0, "bp_next");

        // Reset three BUSY edges into an operation.
        start_op(0, 16'h0077, 16'h0011, 1'b0, 1'b0, "rst");
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_v", out_valid[0], 0);
        chk("rst_mid_s", get_s(0), 0);
        chk("rst_mid_c", c_o[0], 0);
        chk("rst_mid_rdy", in_ready[0], 1);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "rst_after");

        // Random operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            u    = $urandom_range(0, 2);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            if (width_of(u) == 8) begin
                ra[15:8] = 8'h00;
                rb[15:8] = 8'h00;
            end
            rcin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            model(u, ra, rb, rcin, rsub, ms, mc, movf);
            run_op(u, ra, rb, rcin, rsub, ms, mc, movf, $sformatf("rnd%0d_u%0d", i, u));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
